// File: rtl/ram_window_reader.sv
// Streams a circular window of consecutive words out of a 1-cycle-latency RAM as a
// valid/ready stream; a 2-entry FIFO absorbs the read latency so backpressure never stalls a read in flight.
module ram_window_reader #(
  parameter int width_p = 8,
  parameter int depth_p = 512
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [$clog2(depth_p)-1:0] base_addr_i,
  input  logic [$clog2(depth_p):0]   len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       ram_rd_valid_o,
  output logic [$clog2(depth_p)-1:0] ram_rd_addr_o,
  input  logic [width_p-1:0]         ram_rd_data_i,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic [1:0]                 state_o
);
  localparam int aw_lp = $clog2(depth_p);
  localparam logic [aw_lp-1:0] addr_max_lp = aw_lp'(depth_p - 1);
  localparam logic [aw_lp:0]   one_lp      = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state, state_n;
  logic [aw_lp-1:0]   addr;
  logic [aw_lp:0]     issue_count;
  logic [aw_lp:0]     beat_count;
  logic               inflight;
  logic [width_p-1:0] fifo [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         occ;
  logic               done_q, done_n;
  logic               pop, issue;

  // Stream handshake: a word transfers in any cycle where valid_o && ready_i at the rising edge;
  // once valid_o is high, data_o and last_o stay stable until that transfer happens.
  assign valid_o = (occ != 2'd0);
  assign data_o  = fifo[rd_ptr];
  assign last_o  = valid_o && (beat_count == one_lp);
  assign pop     = valid_o && ready_i;

  // Issue only if the word can land in the FIFO: what is buffered plus what is in flight,
  // minus what leaves this cycle, must leave a free slot.
  assign issue = (state == RUN) && (issue_count != '0) &&
                 (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign ram_rd_valid_o = issue;
  assign ram_rd_addr_o  = addr;
  assign busy_o         = (state != IDLE);
  assign done_o         = done_q;
  assign state_o        = state;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) done_n = 1'b1;
          else             state_n = RUN;
        end
      end
      RUN: begin
        if (issue && (issue_count == one_lp)) state_n = DRAIN;
      end
      DRAIN: begin
        if (pop && (beat_count == one_lp)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      addr        <= '0;
      issue_count <= '0;
      beat_count  <= '0;
      inflight    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state    <= state_n;
      done_q   <= done_n;
      inflight <= issue;
      if ((state == IDLE) && start_i && (len_i != '0)) begin
        addr        <= base_addr_i;
        issue_count <= len_i;
        beat_count  <= len_i;
      end else begin
        if (issue) begin
          addr        <= (addr == addr_max_lp) ? '0 : addr + 1'b1;
          issue_count <= issue_count - one_lp;
        end
        if (pop) beat_count <= beat_count - one_lp;
      end
    end
  end

  // The RAM result is only present the cycle after the read, so it is captured unconditionally then.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (inflight) begin
        fifo[wr_ptr] <= ram_rd_data_i;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(inflight && !pop && (occ == 2'd2)));
  end
endmodule

// File: tb/tb_ram_window_reader.sv
// Directed bench for ram_window_reader: behavioural 1-cycle RAM preloaded with RAM[i]=i[7:0],
// one task per scenario with inline expected-vs-observed checks.
module tb_ram_window_reader;
  localparam int W = 8;
  localparam int D = 512;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [8:0]   base_addr = '0;
  logic [9:0]   len = '0;
  logic         busy, done, rd_valid, valid, last;
  logic [8:0]   rd_addr;
  logic [W-1:0] rd_data = '0;
  logic [W-1:0] data;
  logic         ready = 1'b0;
  logic [1:0]   state;

  logic [W-1:0] mem [D];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  logic [8:0]   addr_q[$];
  logic [8:0]   exp_addr_q[$];
  int first_rd, first_valid, done_cyc, last_cnt, last_pos, hold_err;
  logic busy_at_done;

  ram_window_reader #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .base_addr_i(base_addr), .len_i(len),
    .busy_o(busy), .done_o(done), .ram_rd_valid_o(rd_valid), .ram_rd_addr_o(rd_addr),
    .ram_rd_data_i(rd_data), .valid_o(valid), .data_o(data), .last_o(last), .ready_i(ready),
    .state_o(state)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_valid) rd_data <= mem[rd_addr];
  end

  // Driver + monitor: cycle 0 is the cycle start_i is high. Returns in the done_o cycle.
  task automatic run_window(input logic [8:0] b, input logic [9:0] l, input int mode,
                            input int restart_at);
    logic prev_stall;
    logic [W-1:0] prev_data;
    got_q.delete();
    addr_q.delete();
    first_rd = -1; first_valid = -1; done_cyc = -1;
    last_cnt = 0; last_pos = -1; hold_err = 0; busy_at_done = 1'b0;
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 2000; c++) begin
      start     = (c == 0) || (c == restart_at);
      base_addr = (c == 0) ? b : 9'd100;
      len       = (c == 0) ? l : 10'd3;
      ready     = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      if (prev_stall && (!valid || (data !== prev_data))) hold_err++;
      if (rd_valid) begin
        addr_q.push_back(rd_addr);
        if (first_rd < 0) first_rd = c;
      end
      if (valid && (first_valid < 0)) first_valid = c;
      if (valid && ready) begin
        got_q.push_back(data);
        if (last) begin
          last_cnt++;
          last_pos = got_q.size() - 1;
        end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      if (done && (c > 0)) begin
        done_cyc     = c;
        busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, rd_valid, valid, last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {busy, done, rd_valid, valid, last});
    end
    checks++;
    if (rd_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d exp 0", rd_addr);
    end
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %0h exp 0", data);
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d exp 0", state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_window(9'd0, 10'd4, 0, -1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    exp_addr_q = '{9'd0, 9'd1, 9'd2, 9'd3};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i >= got_q.size()) || (got_q[i] !== exp_q[i])) begin
        errors++;
        $display("FAIL basic_data[%0d] got %0h exp %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (addr_q != exp_addr_q) begin
      errors++;
      $display("FAIL basic_addrs got %p exp %p", addr_q, exp_addr_q);
    end
    checks++;
    if ((first_rd != 1) || (first_valid != 3)) begin
      errors++;
      $display("FAIL basic_latency got rd %0d valid %0d exp rd 1 valid 3", first_rd, first_valid);
    end
    checks++;
    if ((last_cnt != 1) || (last_pos != 3)) begin
      errors++;
      $display("FAIL basic_last got cnt %0d pos %0d exp cnt 1 pos 3", last_cnt, last_pos);
    end
    checks++;
    if ((done_cyc != 7) || (busy_at_done !== 1'b0)) begin
      errors++;
      $display("FAIL basic_done got cyc %0d busy %b exp cyc 7 busy 0", done_cyc, busy_at_done);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    run_window(9'd510, 10'd4, 0, -1);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_addr_q = '{9'd510, 9'd511, 9'd0, 9'd1};
    checks++;
    if (addr_q != exp_addr_q) begin
      errors++;
      $display("FAIL wrap_addrs got %p exp %p", addr_q, exp_addr_q);
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL wrap_data got %p exp %p", got_q, exp_q);
    end
    checks++;
    if ((done_cyc != 7) || (last_pos != 3)) begin
      errors++;
      $display("FAIL wrap_done got cyc %0d last %0d exp cyc 7 last 3", done_cyc, last_pos);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    run_window(9'd0, 10'd6, 1, -1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL bp_data got %p exp %p", got_q, exp_q);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d violations exp 0", hold_err);
    end
    checks++;
    if (addr_q.size() != 6) begin
      errors++;
      $display("FAIL bp_reads got %0d exp 6", addr_q.size());
    end
    checks++;
    if ((last_cnt != 1) || (last_pos != 5)) begin
      errors++;
      $display("FAIL bp_last got cnt %0d pos %0d exp cnt 1 pos 5", last_cnt, last_pos);
    end
    checks++;
    if (done_cyc != 19) begin
      errors++;
      $display("FAIL bp_done got %0d exp 19", done_cyc);
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    run_window(9'd5, 10'd0, 0, -1);
    checks++;
    if (done_cyc != 1) begin
      errors++;
      $display("FAIL len0_done got %0d exp 1", done_cyc);
    end
    checks++;
    if ((addr_q.size() != 0) || (first_valid != -1)) begin
      errors++;
      $display("FAIL len0_quiet got reads %0d first_valid %0d exp 0 -1", addr_q.size(), first_valid);
    end
  endtask

  task automatic test_full_depth();
    int bad;
    @(negedge clk);
    run_window(9'd0, 10'd512, 0, -1);
    bad = 0;
    checks++;
    if (got_q.size() != D) begin
      errors++;
      $display("FAIL full_count got %0d exp %0d", got_q.size(), D);
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if ((i >= got_q.size()) || (got_q[i] !== i[7:0])) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL full_data[%0d] got %0h exp %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, i[7:0]);
      end
    end
    checks++;
    if ((last_cnt != 1) || (last_pos != 511)) begin
      errors++;
      $display("FAIL full_last got cnt %0d pos %0d exp cnt 1 pos 511", last_cnt, last_pos);
    end
    checks++;
    if (done_cyc != 515) begin
      errors++;
      $display("FAIL full_done got %0d exp 515", done_cyc);
    end
  endtask

  task automatic test_restart();
    @(negedge clk);
    run_window(9'd20, 10'd5, 0, 4);
    exp_q = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
    checks++;
    if ((got_q != exp_q) || (addr_q.size() != 5)) begin
      errors++;
      $display("FAIL restart_ignored got %p reads %0d exp %p reads 5", got_q, addr_q.size(), exp_q);
    end
    checks++;
    if (done_cyc != 8) begin
      errors++;
      $display("FAIL restart_done got %0d exp 8", done_cyc);
    end
    // still inside the done_o cycle: a new start here must be taken
    run_window(9'd40, 10'd2, 0, -1);
    exp_q = '{8'd40, 8'd41};
    checks++;
    if ((got_q != exp_q) || (done_cyc != 5)) begin
      errors++;
      $display("FAIL back_to_back got %p done %0d exp %p done 5", got_q, done_cyc, exp_q);
    end
  endtask

  task automatic test_async_reset();
    int spurious;
    @(negedge clk);
    start = 1'b1; base_addr = 9'd0; len = 10'd8; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_valid, valid, last} !== 5'b0) begin
      errors++;
      $display("FAIL areset_flags got %b exp 00000", {busy, done, rd_valid, valid, last});
    end
    checks++;
    if ((rd_addr !== 9'd0) || (data !== 8'h00) || (state !== 2'd0)) begin
      errors++;
      $display("FAIL areset_values got addr %0d data %0h state %0d exp 0 0 0", rd_addr, data, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (done || rd_valid || valid) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL areset_quiet got %0d active cycles exp 0", spurious);
    end
    @(negedge clk);
    run_window(9'd0, 10'd4, 0, -1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    checks++;
    if ((got_q != exp_q) || (done_cyc != 7)) begin
      errors++;
      $display("FAIL areset_recover got %p done %0d exp %p done 7", got_q, done_cyc, exp_q);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = i[7:0];
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_full_depth();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
